control_frame_tx: RTL and testbench

//   UART transmitter for the 8-byte steer/throttle control frame: "a","b","c", steer[15:8],

---
 rtl/control_frame_tx_pkg.sv | 25 ++
 rtl/control_frame_tx_byte.sv | 87 ++++++++
 rtl/control_frame_tx.sv | 83 ++++++++
 tb/tb_control_frame_tx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/control_frame_tx_pkg.sv
// Shared definitions for the steer/throttle control frame: header bytes, length,
// serializer state encodings and the checksum used by both transmitter and receiver.
package control_frame_tx_pkg;

  localparam logic [7:0] FRAME_HDR0 = 8'h61;
  localparam logic [7:0] FRAME_HDR1 = 8'h62;
  localparam logic [7:0] FRAME_HDR2 = 8'h63;
  localparam int         FRAME_LEN  = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef struct packed {
    logic [15:0] steer;
    logic [15:0] throttle;
  } ctrlPayload_t;

  function automatic logic [7:0] frameChecksum(input logic [15:0] steer,
                                               input logic [15:0] throttle);
    return steer[15:8] ^ steer[7:0] ^ throttle[15:8] ^ throttle[7:0];
  endfunction

endpackage

// File: rtl/control_frame_tx_byte.sv
// 8N1 byte serializer with a registered line output and a down-counting bit timer.
// byteReady is high in IDLE and on the last clock of a stop bit, so bytes chain with no gap.
//
//   state | meaning
//   IDLE  | line high, waiting for byteValid
//   START | driving the start bit (0)
//   DATA  | driving d0..d7, LSB first
//   STOP  | driving the stop bit (1); may load the next byte on expiry
module uart_tx_byte
  import control_frame_tx_pkg::*;
#(
  parameter int BIT_CLKS = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byteValid,
  input  logic [7:0] byteData,
  output logic       byteReady,
  output logic       txLine
);

  localparam int CNT_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIT_CLKS - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       shiftReg;
  logic [2:0]       bitIdx;
  logic             cntDone;

  assign cntDone   = (cnt == '0);
  assign byteReady = (state == ST_IDLE) || ((state == ST_STOP) && cntDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      shiftReg <= '0;
      bitIdx   <= '0;
      txLine   <= 1'b1;
    end else if (byteValid && byteReady) begin
      state    <= ST_START;
      cnt      <= CNT_LOAD;
      shiftReg <= byteData;
      bitIdx   <= '0;
      txLine   <= 1'b0;
    end else begin
      case (state)
        ST_START: begin
          if (cntDone) begin
            state    <= ST_DATA;
            cnt      <= CNT_LOAD;
            txLine   <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (cntDone) begin
            cnt <= CNT_LOAD;
            if (bitIdx == 3'd7) begin
              state  <= ST_STOP;
              txLine <= 1'b1;
            end else begin
              bitIdx   <= bitIdx + 3'd1;
              txLine   <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STOP: begin
          // Expiry with no next byte pending drops back to idle.
          if (cntDone) state <= ST_IDLE;
          else         cnt   <= cnt - 1'b1;
        end
        default: begin
          state  <= ST_IDLE;
          txLine <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/control_frame_tx.sv
// Frame sequencer: latches steer/throttle on accept and feeds the 8 frame bytes
// (header, payload, XOR checksum) back-to-back into the byte serializer.
module control_frame_tx
  import control_frame_tx_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send,
  input  logic [15:0] steer,
  input  logic [15:0] throttle,
  output logic        busy,
  output logic        done,
  output logic        uart_tx
);

  localparam int         BIT_CLKS = CLK_FREQ / BAUD;
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  ctrlPayload_t payload;
  logic [2:0]   idx;
  logic [2:0]   nextIdx;
  logic [7:0]   byteData;
  logic         byteValid;
  logic         byteReady;
  logic         frameEnd;

  // idx is the byte currently on the line; the serializer is offered the following one.
  assign nextIdx   = busy ? (idx + 3'd1) : 3'd0;
  assign byteValid = busy ? (idx != LAST_IDX) : send;
  assign frameEnd  = busy && byteReady && (idx == LAST_IDX);

  always_comb begin
    byteData = FRAME_HDR0;
    case (nextIdx)
      3'd1:    byteData = FRAME_HDR1;
      3'd2:    byteData = FRAME_HDR2;
      3'd3:    byteData = payload.steer[15:8];
      3'd4:    byteData = payload.steer[7:0];
      3'd5:    byteData = payload.throttle[15:8];
      3'd6:    byteData = payload.throttle[7:0];
      3'd7:    byteData = frameChecksum(payload.steer, payload.throttle);
      default: byteData = FRAME_HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      idx     <= '0;
      payload <= '0;
    end else begin
      done <= frameEnd;
      if (!busy) begin
        if (send) begin
          busy    <= 1'b1;
          idx     <= '0;
          payload <= '{steer: steer, throttle: throttle};
        end
      end else if (frameEnd) begin
        busy <= 1'b0;
        idx  <= '0;
      end else if (byteValid && byteReady) begin
        idx <= idx + 3'd1;
      end
    end
  end

  uart_tx_byte #(
    .BIT_CLKS (BIT_CLKS)
  ) u_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .byteValid (byteValid),
    .byteData  (byteData),
    .byteReady (byteReady),
    .txLine    (uart_tx)
  );

endmodule

// File: tb/tb_control_frame_tx.sv
// Directed + randomized bench for control_frame_tx; the expected line is rebuilt
// from the frame byte list and compared every clock of every frame.
module tb_control_frame_tx;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int BC       = CLK_FREQ / BAUD;
  localparam int FRAME_CLKS = 80 * BC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send = 1'b0;
  logic [15:0] steer = '0;
  logic [15:0] throttle = '0;
  logic        busy;
  logic        done;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;

  logic [7:0] expBytes [0:7];
  logic       expBits  [0:79];
  logic [7:0] decBytes [0:7];

  control_frame_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .send     (send),
    .steer    (steer),
    .throttle (throttle),
    .busy     (busy),
    .done     (done),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setModel(input logic [15:0] s, input logic [15:0] t);
    expBytes[0] = 8'h61;
    expBytes[1] = 8'h62;
    expBytes[2] = 8'h63;
    expBytes[3] = s[15:8];
    expBytes[4] = s[7:0];
    expBytes[5] = t[15:8];
    expBytes[6] = t[7:0];
    expBytes[7] = s[15:8] ^ s[7:0] ^ t[15:8] ^ t[7:0];
    for (int j = 0; j < 8; j++) begin
      expBits[j*10] = 1'b0;
      for (int b = 0; b < 8; b++) expBits[j*10+1+b] = expBytes[j][b];
      expBits[j*10+9] = 1'b1;
    end
  endtask

  task automatic kick(input logic [15:0] s, input logic [15:0] t);
    steer = s;
    throttle = t;
    send = 1'b1;
  endtask

  // Entered at a negedge with send already high for the frame (s,t).
  task automatic runFrame(input logic [15:0] s, input logic [15:0] t, input int injectAt,
                          input bit holdNext, input logic [15:0] ns, input logic [15:0] nt);
    int lineErr;
    int bitPos;
    setModel(s, t);
    lineErr = 0;
    @(negedge clk);
    send = 1'b0;
    for (int k = 0; k < FRAME_CLKS; k++) begin
      if (k > 0) @(negedge clk);
      if (uart_tx !== expBits[k/BC] || busy !== 1'b1 || done !== 1'b0) lineErr++;
      if (k % BC == BC/2) begin
        bitPos = (k / BC) % 10;
        if (bitPos >= 1 && bitPos <= 8) decBytes[k/(10*BC)][bitPos-1] = uart_tx;
      end
      if (k == injectAt) begin
        steer = 16'hFFFF;
        throttle = ~t;
        send = 1'b1;
      end else if (k == injectAt + 1) begin
        send = 1'b0;
      end
    end
    check("frame_line_busy_errs", lineErr, 0);
    for (int j = 0; j < 8; j++) check($sformatf("byte%0d", j), decBytes[j], expBytes[j]);
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    check("busy_end", busy, 1'b0);
    check("tx_end", uart_tx, 1'b1);
    if (holdNext) begin
      kick(ns, nt);
    end else begin
      @(negedge clk);
      check("done_single", done, 1'b0);
      check("idle_busy", busy, 1'b0);
    end
  endtask

  initial begin
    int idleErr;
    logic [15:0] s1, t1, s2, t2, s3, t3;
    int inj;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", uart_tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    idleErr = 0;
    repeat (200) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idleErr++;
    end
    check("idle_200", idleErr, 0);

    kick(16'h01F4, 16'h0300);
    runFrame(16'h01F4, 16'h0300, -10, 1'b0, '0, '0);

    kick(16'h1234, 16'hABCD);
    runFrame(16'h1234, 16'hABCD, 300, 1'b0, '0, '0);
    idleErr = 0;
    repeat (50) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idleErr++;
    end
    check("no_second_frame", idleErr, 0);

    s1 = 16'($urandom); t1 = 16'($urandom);
    s2 = 16'($urandom); t2 = 16'($urandom);
    kick(s1, t1);
    runFrame(s1, t1, -10, 1'b1, s2, t2);
    runFrame(s2, t2, -10, 1'b0, '0, '0);

    s3 = 16'($urandom); t3 = 16'($urandom);
    kick(s3, t3);
    @(negedge clk);
    send = 1'b0;
    repeat (250) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", uart_tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_tx", uart_tx, 1'b1);
    kick(16'h05DC, 16'h0200);
    runFrame(16'h05DC, 16'h0200, -10, 1'b0, '0, '0);

    for (int r = 0; r < 3; r++) begin
      s1 = 16'($urandom); t1 = 16'($urandom);
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FRAME_CLKS - 10)) : -10;
      kick(s1, t1);
      runFrame(s1, t1, inj, 1'b0, '0, '0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
